// File: rtl/usbfs_tx_pkt.sv
// usbfs_tx_pkt: IN-endpoint packet buffer and response serialiser (DATA PID/payload/CRC16 or NAK/STALL),
// with DATA0/DATA1 toggle tracking and retransmission of unACKed packets.
module usbfs_tx_pkt #(
  parameter int MAX_PKT = 8,
  parameter int IDX_W = $clog2(MAX_PKT),
  parameter int NB_W = $clog2(MAX_PKT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_etReady,
  input  logic             i_etValid,
  input  logic             i_etStall,
  input  logic             i_etWrEn,
  input  logic [IDX_W-1:0] i_etWrIdx,
  input  logic [7:0]       i_etWrByte,
  input  logic [NB_W-1:0]  i_etWrNBytes,
  input  logic             i_inTok,
  input  logic             i_ackRcvd,
  input  logic             i_timeout,
  input  logic             i_toggleClr,
  output logic             o_txValid,
  input  logic             i_txReady,
  output logic [7:0]       o_txData,
  output logic             o_txLast
);
  typedef enum logic [2:0] {IDLE, FILL, SEND, WAIT_ACK, HOLD} state_t;
  state_t          r_state;
  logic            r_toggle;
  logic            r_hs;
  logic [NB_W-1:0] r_nb;
  logic [NB_W:0]   r_pos;
  logic [15:0]     r_crc;
  logic [7:0]      r_buf [MAX_PKT];
  logic            w_acc;
  logic            w_tok;
  logic            w_hs;
  logic            w_pay;
  logic [NB_W:0]   w_p;
  logic [NB_W:0]   w_nbx;
  logic [NB_W:0]   w_nb1;
  logic [15:0]     w_crc;
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) x = x[0] ? (x >> 1) ^ 16'hA001 : x >> 1;
    return x;
  endfunction
  assign o_etReady = r_state == IDLE && !i_etStall;
  assign w_acc = o_txValid && i_txReady;
  assign w_tok = i_inTok && r_state != SEND;
  assign w_hs = r_state == IDLE || i_etStall;
  assign w_p = r_pos + 1'b1;
  assign w_nbx = {1'b0, r_nb};
  assign w_nb1 = w_nbx + 1'b1;
  // r_pos: 0 = PID, 1..nb = payload, nb+1/nb+2 = CRC bytes
  assign w_pay = r_pos != '0 && r_pos <= w_nbx;
  assign w_crc = w_pay ? crc_upd(r_crc, o_txData) : r_crc;
  always_ff @(posedge i_clk)
    if (r_state == FILL && i_etWrEn) r_buf[i_etWrIdx] <= i_etWrByte;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_toggle <= 1'b0;
      r_hs <= 1'b0;
      r_nb <= '0;
      r_pos <= '0;
      r_crc <= 16'hFFFF;
      o_txValid <= 1'b0;
      o_txData <= 8'h00;
      o_txLast <= 1'b0;
    end else begin
      r_toggle <= !i_toggleClr && (r_toggle ^ (r_state == WAIT_ACK && i_ackRcvd && !i_inTok));
      if (r_state == FILL && i_inTok) r_nb <= i_etWrNBytes + NB_W'(i_etWrEn);
      if (w_tok) begin
        r_state <= SEND;
        r_hs <= w_hs;
        r_pos <= '0;
        r_crc <= 16'hFFFF;
        o_txValid <= 1'b1;
        o_txLast <= w_hs;
        o_txData <= w_hs ? (i_etStall ? 8'h1E : 8'h5A) : (r_toggle ? 8'h4B : 8'hC3);
      end else
        case (r_state)
          IDLE: if (i_etValid && o_etReady) r_state <= FILL;
          WAIT_ACK: r_state <= i_ackRcvd ? IDLE : i_timeout ? HOLD : WAIT_ACK;
          SEND:
            if (w_acc) begin
              if (o_txLast) begin
                o_txValid <= 1'b0;
                o_txLast <= 1'b0;
                r_state <= r_hs ? IDLE : WAIT_ACK;
              end else begin
                r_pos <= w_p;
                r_crc <= w_crc;
                o_txData <= w_p <= w_nbx ? r_buf[r_pos[IDX_W-1:0]] : w_p == w_nb1 ? ~w_crc[7:0] : ~w_crc[15:8];
                o_txLast <= w_p > w_nb1;
              end
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_usbfs_tx_pkt.sv
// tb_usbfs_tx_pkt: directed bench for usbfs_tx_pkt with MAX_PKT=16.
module tb_usbfs_tx_pkt;
  localparam int MAX_PKT = 16;
  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       o_etReady;
  logic       i_etValid;
  logic       i_etStall;
  logic       i_etWrEn;
  logic [3:0] i_etWrIdx;
  logic [7:0] i_etWrByte;
  logic [4:0] i_etWrNBytes;
  logic       i_inTok;
  logic       i_ackRcvd;
  logic       i_timeout;
  logic       i_toggleClr;
  logic       o_txValid;
  logic       i_txReady;
  logic [7:0] o_txData;
  logic       o_txLast;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pl[$];
  always #5 i_clk = ~i_clk;
  usbfs_tx_pkt #(.MAX_PKT(MAX_PKT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .o_etReady(o_etReady), .i_etValid(i_etValid),
    .i_etStall(i_etStall), .i_etWrEn(i_etWrEn), .i_etWrIdx(i_etWrIdx), .i_etWrByte(i_etWrByte),
    .i_etWrNBytes(i_etWrNBytes), .i_inTok(i_inTok), .i_ackRcvd(i_ackRcvd), .i_timeout(i_timeout),
    .i_toggleClr(i_toggleClr), .o_txValid(o_txValid), .i_txReady(i_txReady), .o_txData(o_txData),
    .o_txLast(o_txLast)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask
  // Bit-serial reference CRC (LSB first, reflected 0xA001, init 0xFFFF), returns the inverted value sent on the wire
  function automatic logic [15:0] crc_model(input logic [7:0] q[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (q[i])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    return ~c;
  endfunction
  task automatic mk_data(input logic [7:0] pid, input logic [7:0] p[$]);
    logic [15:0] c;
    c = crc_model(p);
    exp_q = {pid};
    foreach (p[i]) exp_q.push_back(p[i]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask
  task automatic fill(input logic [7:0] p[$]);
    i_etValid = 1'b1;
    @(negedge i_clk);
    i_etValid = 1'b0;
    foreach (p[i]) begin
      i_etWrEn = 1'b1;
      i_etWrIdx = 4'(i);
      i_etWrByte = p[i];
      i_etWrNBytes = 5'(i);
      @(negedge i_clk);
    end
    i_etWrEn = 1'b0;
    i_etWrNBytes = 5'(p.size());
  endtask
  task automatic in_tok(input string tag);
    i_inTok = 1'b1;
    @(negedge i_clk);
    i_inTok = 1'b0;
    chk({tag, "_first_valid"}, 16'(o_txValid), 16'd1);
  endtask
  task automatic pulse_ack();
    i_ackRcvd = 1'b1;
    @(negedge i_clk);
    i_ackRcvd = 1'b0;
  endtask
  task automatic pulse_timeout();
    i_timeout = 1'b1;
    @(negedge i_clk);
    i_timeout = 1'b0;
  endtask
  // Consumes one packet, comparing each accepted byte with exp_q; bp enables random backpressure
  task automatic recv(input string tag, input bit bp);
    int k = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [7:0] hd = 8'h00;
    while (k < exp_q.size() && cyc < 500) begin
      i_txReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_txValid) begin
        if (hold) chk({tag, "_stable"}, 16'(o_txData), 16'(hd));
        if (i_txReady) begin
          chk($sformatf("%s_b%0d", tag, k), 16'(o_txData), 16'(exp_q[k]));
          chk($sformatf("%s_last%0d", tag, k), 16'(o_txLast), 16'(k == exp_q.size() - 1));
          k++;
        end
        hold = !i_txReady;
        hd = o_txData;
      end else if (!bp) chk({tag, "_bubble"}, 16'(o_txValid), 16'd1);
      @(negedge i_clk);
      cyc++;
    end
    i_txReady = 1'b1;
    chk({tag, "_count"}, 16'(k), 16'(exp_q.size()));
    chk({tag, "_end_valid"}, 16'(o_txValid), 16'd0);
  endtask
  initial begin
    i_rst_n = 1'b0;
    i_etValid = 1'b0;
    i_etStall = 1'b0;
    i_etWrEn = 1'b0;
    i_etWrIdx = '0;
    i_etWrByte = '0;
    i_etWrNBytes = '0;
    i_inTok = 1'b0;
    i_ackRcvd = 1'b0;
    i_timeout = 1'b0;
    i_toggleClr = 1'b0;
    i_txReady = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("rst_valid", 16'(o_txValid), 16'd0);
    chk("rst_data", 16'(o_txData), 16'd0);
    chk("rst_last", 16'(o_txLast), 16'd0);
    chk("rst_ready", 16'(o_etReady), 16'd1);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    // NAK from IDLE
    in_tok("nak");
    exp_q = {8'h5A};
    recv("nak", 1'b0);
    chk("nak_ready", 16'(o_etReady), 16'd1);
    // STALL from IDLE
    i_etStall = 1'b1;
    #1 chk("stall_ready", 16'(o_etReady), 16'd0);
    @(negedge i_clk);
    in_tok("stall_idle");
    exp_q = {8'h1E};
    recv("stall_idle", 1'b0);
    // STALL from FILL drops the buffer
    i_etStall = 1'b0;
    pl = {8'hAA, 8'hBB, 8'hCC};
    fill(pl);
    chk("fill_ready", 16'(o_etReady), 16'd0);
    i_etStall = 1'b1;
    in_tok("stall_fill");
    exp_q = {8'h1E};
    recv("stall_fill", 1'b0);
    i_etStall = 1'b0;
    #1 chk("drop_ready", 16'(o_etReady), 16'd1);
    @(negedge i_clk);
    in_tok("drop_nak");
    exp_q = {8'h5A};
    recv("drop_nak", 1'b0);
    // "123456789" with DATA0, then DATA1 after ACK
    pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    fill(pl);
    in_tok("d0");
    exp_q = {8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
    recv("d0", 1'b0);
    chk("wait_ready", 16'(o_etReady), 16'd0);
    pulse_ack();
    chk("ack_ready", 16'(o_etReady), 16'd1);
    fill(pl);
    in_tok("d1");
    exp_q[0] = 8'h4B;
    recv("d1", 1'b0);
    pulse_ack();
    // Zero-length packet, timeout and identical resend
    pl = {};
    fill(pl);
    in_tok("zlp");
    exp_q = {8'hC3, 8'h00, 8'h00};
    recv("zlp", 1'b0);
    pulse_timeout();
    in_tok("zlp_re");
    recv("zlp_re", 1'b0);
    pulse_ack();
    chk("zlp_ack_ready", 16'(o_etReady), 16'd1);
    // 8-byte packet, then the same packet under random backpressure
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    fill(pl);
    in_tok("nbp");
    mk_data(8'h4B, pl);
    recv("nbp", 1'b0);
    pulse_timeout();
    in_tok("bp");
    recv("bp", 1'b1);
    pulse_ack();
    // Write at idx 3 coincident with the IN token is counted
    pl = {8'h10, 8'h20, 8'h30};
    fill(pl);
    i_etWrEn = 1'b1;
    i_etWrIdx = 4'd3;
    i_etWrByte = 8'h40;
    i_etWrNBytes = 5'd3;
    in_tok("co");
    i_etWrEn = 1'b0;
    pl = {8'h10, 8'h20, 8'h30, 8'h40};
    mk_data(8'hC3, pl);
    recv("co", 1'b0);
    // ACK with toggle clear in the same cycle leaves DATA0
    i_ackRcvd = 1'b1;
    i_toggleClr = 1'b1;
    @(negedge i_clk);
    i_ackRcvd = 1'b0;
    i_toggleClr = 1'b0;
    pl = {8'h77};
    fill(pl);
    in_tok("clr");
    mk_data(8'hC3, pl);
    recv("clr", 1'b0);
    pulse_ack();
    // Async reset mid-payload aborts and resets the toggle
    pl = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
    fill(pl);
    in_tok("rs");
    chk("rs_pid", 16'(o_txData), 16'h004B);
    repeat (2) @(negedge i_clk);
    chk("rs_mid", 16'(o_txData), 16'h00A2);
    #2 i_rst_n = 1'b0;
    #1 chk("rs_valid", 16'(o_txValid), 16'd0);
    chk("rs_last", 16'(o_txLast), 16'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rs_quiet", 16'(o_txValid), 16'd0);
    pl = {8'h55};
    fill(pl);
    in_tok("post_rst");
    mk_data(8'hC3, pl);
    recv("post_rst", 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
